// File: rtl/store_if.sv
// Core-to-store-unit request handshake and store-unit-to-memory write port.
// The slave modport is the store unit; the master modport drives its inputs.
interface store_if;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        st_done;
  logic        st_misaligned;
  logic        st_illegal;
  logic        st_timeout;

  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb,
           st_done, st_misaligned, st_illegal, st_timeout
  );

  modport master (
    output st_valid, st_funct3, st_addr, st_data, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb,
           st_done, st_misaligned, st_illegal, st_timeout
  );
endinterface

// File: rtl/store_unit.sv
// SB/SH/SW store unit: lane-replicates data, builds byte strobes, holds a
// single memory write until ack or timeout, and reports status as pulses.
module store_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic   clk,
  input  logic   rst_n,
  store_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [9:0] LAST_WAIT = 10'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;
  logic        to_q, to_d;

  logic        req_illegal;
  logic        req_misaligned;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;

  // Width decode of the presented request; only used on the accepting edge.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    req_wdata      = bus.st_data;
    req_wstrb      = 4'b1111;
    case (bus.st_funct3)
      3'b000: begin
        req_wdata = {4{bus.st_data[7:0]}};
        req_wstrb = 4'b0001 << bus.st_addr[1:0];
      end
      3'b001: begin
        req_wdata      = {2{bus.st_data[15:0]}};
        req_wstrb      = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        req_misaligned = bus.st_addr[0];
      end
      3'b010: begin
        req_misaligned = (bus.st_addr[1:0] != 2'b00);
      end
      default: req_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    ill_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.st_valid) begin
          if (req_illegal) begin
            ill_d = 1'b1;
          end else if (req_misaligned) begin
            mis_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
            addr_d  = {bus.st_addr[31:2], 2'b00};
            wdata_d = req_wdata;
            wstrb_d = req_wstrb;
          end
        end
      end
      WAIT: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (bus.mem_ack) begin
          state_d = IDLE;
          wstrb_d = 4'b0000;
          done_d  = 1'b1;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = IDLE;
          wstrb_d = 4'b0000;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end

  assign bus.st_ready      = (state_q == IDLE);
  assign bus.mem_req       = (state_q == WAIT);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wstrb     = wstrb_q;
  assign bus.st_done       = done_q;
  assign bus.st_misaligned = mis_q;
  assign bus.st_illegal    = ill_q;
  assign bus.st_timeout    = to_q;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed cases followed by random
// stores compared against a width/alignment reference model.
module tb_store_unit;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  store_if bus ();

  store_unit #(.ACK_TIMEOUT(T)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {bus.st_done, bus.st_misaligned, bus.st_illegal, bus.st_timeout};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ack_dly: WAIT cycle index (0 = first) in which ack is driven; >= T means never.
  task automatic run_store(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input int ack_dly);
    int          n;
    int          size;
    int          kind;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    bit          acked;
    // Reference: status, replicated data and strobes from width arithmetic.
    size     = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    kind     = (f3 > 3'd2) ? 2 : ((addr % size) != 0) ? 1 : 0;
    exp_data = (size == 1) ? (data & 32'hFF) * 32'h01010101 :
               (size == 2) ? (data & 32'hFFFF) * 32'h00010001 : data;
    exp_strb = 4'(((1 << size) - 1) << (addr % 4));

    n = 0;
    while (!bus.st_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_before", 32'(bus.st_ready), 32'd1);
    bus.st_valid  = 1'b1;
    bus.st_funct3 = f3;
    bus.st_addr   = addr;
    bus.st_data   = data;
    step();
    bus.st_valid  = 1'b0;
    bus.st_funct3 = 3'($urandom);
    bus.st_addr   = $urandom;
    bus.st_data   = $urandom;

    if (kind != 0) begin
      check("err_pulse", 32'(pulses()), (kind == 1) ? 32'h4 : 32'h2);
      check("err_mem_req", 32'(bus.mem_req), 32'd0);
      check("err_wstrb", 32'(bus.mem_wstrb), 32'd0);
      check("err_ready", 32'(bus.st_ready), 32'd1);
      $display("store f3=%0d addr=0x%08h -> %s", f3, addr, (kind == 1) ? "misaligned" : "illegal");
    end else begin
      acked = 1'b0;
      for (int k = 0; k < T && !acked; k++) begin
        check("wait_mem_req", 32'(bus.mem_req), 32'd1);
        check("wait_addr", bus.mem_addr, addr - (addr % 4));
        check("wait_wdata", bus.mem_wdata, exp_data);
        check("wait_wstrb", 32'(bus.mem_wstrb), 32'(exp_strb));
        check("wait_pulses", 32'(pulses()), 32'h0);
        check("wait_ready", 32'(bus.st_ready), 32'd0);
        if (k == ack_dly) begin
          bus.mem_ack = 1'b1;
          acked = 1'b1;
        end
        step();
        bus.mem_ack = 1'b0;
      end
      check(acked ? "done_pulse" : "timeout_pulse", 32'(pulses()), acked ? 32'h8 : 32'h1);
      check("end_mem_req", 32'(bus.mem_req), 32'd0);
      check("end_wstrb", 32'(bus.mem_wstrb), 32'd0);
      check("end_ready", 32'(bus.st_ready), 32'd1);
      $display("store f3=%0d addr=0x%08h data=0x%08h wdata=0x%08h wstrb=%04b -> %s",
               f3, addr, data, exp_data, exp_strb, acked ? "done" : "timeout");
    end
  endtask

  initial begin
    bus.st_valid  = 1'b0;
    bus.st_funct3 = 3'd0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.mem_ack   = 1'b0;
    #3;
    check("rst_ready", 32'(bus.st_ready), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("rst_pulses", 32'(pulses()), 32'h0);
    #10 rst_n = 1'b1;
    step();

    run_store(3'b000, 32'h0000_1003, 32'hAABB_CCDD, 2);
    run_store(3'b001, 32'h0000_2002, 32'h1234_5678, 0);
    run_store(3'b010, 32'h0000_3001, 32'h0BAD_F00D, 0);
    run_store(3'b011, 32'h0000_3001, 32'h0BAD_F00D, 0);
    run_store(3'b010, 32'h0000_4000, 32'hCAFE_BABE, T);
    run_store(3'b010, 32'h0000_5004, 32'h0123_4567, T - 1);

    // Ack while idle must be ignored.
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("idle_ack_pulses", 32'(pulses()), 32'h0);
    check("idle_ack_mem_req", 32'(bus.mem_req), 32'd0);

    // Reset asserted mid-WAIT aborts the store with no trailing pulse.
    bus.st_valid  = 1'b1;
    bus.st_funct3 = 3'b010;
    bus.st_addr   = 32'h0000_6000;
    bus.st_data   = 32'hDEAD_BEEF;
    step();
    bus.st_valid = 1'b0;
    step();
    check("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("mid_rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("mid_rst_ready", 32'(bus.st_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < T + 2; i++) begin
      step();
      check("post_rst_pulses", 32'(pulses()), 32'h0);
      check("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
    end
    $display("reset during WAIT -> aborted");

    for (int i = 0; i < 200; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        bus.mem_ack = 1'($urandom);
        step();
        bus.mem_ack = 1'b0;
        check("gap_pulses", 32'(pulses()), 32'h0);
      end
      run_store(f3, $urandom, $urandom, $urandom_range(0, T + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, SHALL set the maximum number of cycles spent waiting for mem_ack before the store is abandoned (legal range 1..1023).
REQ-002 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset SHALL be asynchronous and active-low.
REQ-004 st_valid  input  1  core presents a store request.
REQ-005 st_ready  output  1  unit can accept a request.
REQ-006 st_funct3  input  3  store width: 000=SB, 001=SH, 010=SW.
REQ-007 st_addr  input  32  byte address.
REQ-008 st_data  input  32  register source data.
REQ-009 mem_req  output  1  write request to data memory.
REQ-010 mem_addr  output  32  word-aligned address, {st_addr[31:2],2'b00}.
REQ-011 mem_wdata  output  32  lane-replicated write data.
REQ-012 mem_wstrb  output  4  byte-lane write enables.
REQ-013 mem_ack  input  1  memory has completed the write.
REQ-014 st_done  output  1  one-cycle pulse: store completed.
REQ-015 st_misaligned  output  1  one-cycle pulse: address not aligned to the store width.
REQ-016 st_illegal  output  1  one-cycle pulse: funct3 not in {000,001,010}.
REQ-017 st_timeout  output  1  one-cycle pulse: ack not received within ACK_TIMEOUT cycles.

Function
REQ-018 The FSM SHALL have two states: IDLE and WAIT; st_ready SHALL be 1 exactly when the state is IDLE.
REQ-019 A request SHALL be accepted on a rising edge where st_valid=1 and st_ready=1; inputs SHALL be sampled only then.
REQ-020 SB: mem_wdata = st_data[7:0] replicated into all four bytes; mem_wstrb = 4'b0001 << st_addr[1:0]; never misaligned.
REQ-021 SH: mem_wdata = {st_data[15:0],st_data[15:0]}; mem_wstrb = 4'b1100 if st_addr[1]=1, otherwise 4'b0011; misaligned if st_addr[0]=1.
REQ-022 SW: mem_wdata = st_data; mem_wstrb = 4'b1111; misaligned if st_addr[1:0]!=0.
REQ-023 On an accepted legal, aligned request, the unit SHALL register mem_addr, mem_wdata and mem_wstrb, enter WAIT, and assert mem_req from the next cycle onward.
REQ-024 In WAIT, mem_req, mem_addr, mem_wdata and mem_wstrb SHALL stay stable until the cycle in which mem_ack=1 is sampled.
REQ-025 On mem_ack=1 in WAIT: return to IDLE, deassert mem_req, and pulse st_done for exactly one cycle (the cycle after the ack).
REQ-026 mem_ack SHALL be ignored in IDLE.
REQ-027 A wait counter SHALL clear on entering WAIT and increment each WAIT cycle without ack.
REQ-028 When the counter reaches ACK_TIMEOUT, the unit SHALL return to IDLE, deassert mem_req, and pulse st_timeout; no st_done SHALL be produced for that store.
REQ-029 If mem_ack arrives in the same cycle the counter reaches ACK_TIMEOUT, ack SHALL win: st_done pulses and st_timeout does not.
REQ-030 An accepted illegal funct3 request SHALL cause no memory request, keep the state IDLE, and pulse st_illegal the next cycle; illegal funct3 SHALL take priority over misalignment.
REQ-031 An accepted misaligned request SHALL cause no memory request, keep the state IDLE, and pulse st_misaligned the next cycle.
REQ-032 At most one of st_done, st_misaligned, st_illegal and st_timeout SHALL be high in any cycle.
REQ-033 Back-to-back requests SHALL be supported; a new request may be accepted in the same cycle st_done pulses.
REQ-034 When mem_req=0, mem_wstrb SHALL be 4'b0000.

Reset
REQ-035 While rst_n=0: state=IDLE, mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, the counter is 0, all pulse outputs are 0, and st_ready=1.
REQ-036 Reset asserted in WAIT SHALL abort the store immediately, with no st_done or st_timeout pulse after release.

Verification
REQ-037 SB, addr=0x1003, data=0xAABBCCDD, ack 2 cycles later -> mem_addr=0x1000, wdata=0xDDDDDDDD, wstrb=1000, st_done pulses once.
REQ-038 SH, addr=0x2002, data=0x12345678, ack immediate -> wdata=0x56785678, wstrb=1100, st_done the cycle after the ack.
REQ-039 SW, addr=0x3001 -> st_misaligned pulse, mem_req never asserted; then funct3=011 -> st_illegal pulse only.
REQ-040 ACK_TIMEOUT=4, SW with no ack -> mem_req high for 4 cycles, then st_timeout pulse, then st_ready=1.
REQ-041 ACK_TIMEOUT=4, ack on the 4th WAIT cycle -> st_done only; separately, rst_n low in WAIT -> mem_req=0 immediately and no pulse after release.
